hwpe_sm_port_arbiter: RTL and testbench

- Shares one TCDM LINT master port among N_REQ HLS accelerator memory ports that use the active-low cs_n/wait_n protocol.
- Round-robin arbitration; one outstanding transaction at a time.
- Converts accelerator word indices to byte addresses relative to a per-port base address.
- Sits between the accelerator core and the cluster TCDM interconnect, one instance per shared master port.

---
 rtl/hwpe_sm_arb_pkg.sv | 15 +
 rtl/hwpe_sm_rr_arbiter.sv | 33 +++
 rtl/hwpe_sm_port_arbiter.sv | 152 +++++++++++++++
 tb/tb_hwpe_sm_port_arbiter.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/hwpe_sm_arb_pkg.sv
// Shared types and constants for the HWPE shared-memory port arbiter.
package hwpe_sm_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RESP,
        ACK
    } arb_state_t;

    localparam logic        ACC_TYPE_WRITE = 1'b1;
    localparam logic        TCDM_TYPE_READ = 1'b1;
    localparam int unsigned WORD_SHIFT     = 2;

endpackage

// File: rtl/hwpe_sm_rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after ptr_i, wrapping.
module hwpe_sm_rr_arbiter #(
    parameter int unsigned N_REQ = 4,
    localparam int unsigned IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N_REQ-1:0] gnt_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             any_req_o
);

    int unsigned pos;
    logic        found;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        pos   = 0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            pos = (32'(ptr_i) + k) % N_REQ;
            if (!found && req_i[IDX_W'(pos)]) begin
                found               = 1'b1;
                gnt_o[IDX_W'(pos)]  = 1'b1;
                idx_o               = IDX_W'(pos);
            end
        end
    end

    assign any_req_o = |req_i;

endmodule

// File: rtl/hwpe_sm_port_arbiter.sv
// Shares one TCDM LINT master port among N_REQ cs_n/wait_n accelerator ports (round-robin).
// Optional performance counters enabled by defining HWPE_SM_ARB_PERF_EN.
module hwpe_sm_port_arbiter
    import hwpe_sm_arb_pkg::*;
#(
    parameter int unsigned N_REQ      = 4,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned BE_WIDTH   = DATA_WIDTH/8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        en_i,
    input  logic [N_REQ*ADDR_WIDTH-1:0] base_addr_i,
    input  logic [N_REQ-1:0]            acc_cs_n_i,
    input  logic [N_REQ-1:0]            acc_type_i,
    input  logic [N_REQ*ADDR_WIDTH-1:0] acc_addr_i,
    input  logic [N_REQ*BE_WIDTH-1:0]   acc_be_i,
    input  logic [N_REQ*DATA_WIDTH-1:0] acc_wdata_i,
    output logic [N_REQ-1:0]            acc_wait_n_o,
    output logic [DATA_WIDTH-1:0]       acc_rdata_o,
    output logic                        tcdm_req_o,
    input  logic                        tcdm_gnt_i,
    output logic [ADDR_WIDTH-1:0]       tcdm_add_o,
    output logic                        tcdm_type_o,
    output logic [BE_WIDTH-1:0]         tcdm_be_o,
    output logic [DATA_WIDTH-1:0]       tcdm_data_o,
    input  logic [DATA_WIDTH-1:0]       tcdm_r_data_i,
    input  logic                        tcdm_r_valid_i,
`ifdef HWPE_SM_ARB_PERF_EN
    input  logic                        perf_clear_i,
    output logic [31:0]                 perf_stall_o,
    output logic [31:0]                 perf_xact_o,
`endif
    output logic                        busy_o
);

    localparam int unsigned IDX_W = $clog2(N_REQ);

    arb_state_t             state_q, state_d;
    logic [IDX_W-1:0]       ptr_q, winner_q, arb_idx;
    logic [N_REQ-1:0]       acc_req, arb_gnt, ack_mask;
    logic                   arb_any, launch;
    logic [ADDR_WIDTH-1:0]  sel_base, sel_addr;
    logic [BE_WIDTH-1:0]    sel_be;
    logic [DATA_WIDTH-1:0]  sel_wdata;
    logic                   sel_type;

    assign acc_req = ~acc_cs_n_i;

    hwpe_sm_rr_arbiter #(
        .N_REQ (N_REQ)
    ) i_rr_arbiter (
        .req_i     (acc_req),
        .ptr_i     (ptr_q),
        .gnt_o     (arb_gnt),
        .idx_o     (arb_idx),
        .any_req_o (arb_any)
    );

    // One-hot AND-OR mux of the winning port's request fields
    always_comb begin
        sel_base  = '0;
        sel_addr  = '0;
        sel_be    = '0;
        sel_wdata = '0;
        sel_type  = 1'b0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (arb_gnt[i]) begin
                sel_base  |= base_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_addr  |= acc_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_be    |= acc_be_i[i*BE_WIDTH +: BE_WIDTH];
                sel_wdata |= acc_wdata_i[i*DATA_WIDTH +: DATA_WIDTH];
                sel_type  |= acc_type_i[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        launch  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (en_i && arb_any) begin
                    state_d = REQ;
                    launch  = 1'b1;
                end
            end
            REQ:     if (tcdm_gnt_i) state_d = (tcdm_type_o == TCDM_TYPE_READ) ? RESP : ACK;
            RESP:    if (tcdm_r_valid_i) state_d = ACK;
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q       <= '0;
            winner_q    <= '0;
            tcdm_add_o  <= '0;
            tcdm_type_o <= 1'b0;
            tcdm_be_o   <= '0;
            tcdm_data_o <= '0;
            acc_rdata_o <= '0;
        end else begin
            if (launch) begin
                winner_q    <= arb_idx;
                tcdm_add_o  <= sel_base + (sel_addr << WORD_SHIFT);
                tcdm_type_o <= (sel_type == ACC_TYPE_WRITE) ? ~TCDM_TYPE_READ : TCDM_TYPE_READ;
                tcdm_be_o   <= sel_be;
                tcdm_data_o <= sel_wdata;
            end
            if (state_q == RESP && tcdm_r_valid_i)
                acc_rdata_o <= tcdm_r_data_i;
            if (state_q == ACK)
                ptr_q <= (winner_q == IDX_W'(N_REQ-1)) ? '0 : winner_q + IDX_W'(1);
        end
    end

    assign ack_mask     = (state_q == ACK) ? (N_REQ'(1) << winner_q) : '0;
    assign acc_wait_n_o = acc_cs_n_i | ack_mask;
    assign tcdm_req_o   = (state_q == REQ);
    assign busy_o       = (state_q != IDLE);

`ifdef HWPE_SM_ARB_PERF_EN
    logic stall_now;
    assign stall_now = |(acc_req & ~acc_wait_n_o);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall_o <= '0;
            perf_xact_o  <= '0;
        end else if (perf_clear_i) begin
            perf_stall_o <= '0;
            perf_xact_o  <= '0;
        end else begin
            if (stall_now && perf_stall_o != '1) perf_stall_o <= perf_stall_o + 32'd1;
            if (state_q == ACK)                  perf_xact_o  <= perf_xact_o + 32'd1;
        end
    end
`endif

    // The winning accelerator must keep its request asserted until its ACK cycle
    a_winner_holds_req: assert property (@(posedge clk) disable iff (!rst_n)
        (state_q == REQ || state_q == RESP) |-> !acc_cs_n_i[winner_q]);

endmodule

// File: tb/tb_hwpe_sm_port_arbiter.sv
// Directed self-checking bench for hwpe_sm_port_arbiter (N_REQ=4, 32-bit address/data).
module tb_hwpe_sm_port_arbiter;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         en_i;
    logic [127:0] base_addr_i, acc_addr_i, acc_wdata_i;
    logic [3:0]   acc_cs_n_i, acc_type_i, acc_wait_n_o;
    logic [15:0]  acc_be_i;
    logic [31:0]  acc_rdata_o, tcdm_add_o, tcdm_data_o, tcdm_r_data_i;
    logic         tcdm_req_o, tcdm_gnt_i, tcdm_type_o, tcdm_r_valid_i, busy_o;
    logic [3:0]   tcdm_be_o;

    logic [31:0]  base_m [4];
    logic [31:0]  addr_m [4];
    logic [31:0]  wdata_m[4];
    logic [3:0]   be_m   [4];

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            base_addr_i[i*32 +: 32] = base_m[i];
            acc_addr_i[i*32 +: 32]  = addr_m[i];
            acc_wdata_i[i*32 +: 32] = wdata_m[i];
            acc_be_i[i*4 +: 4]      = be_m[i];
        end
    end

    hwpe_sm_port_arbiter #(
        .N_REQ      (4),
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .en_i           (en_i),
        .base_addr_i    (base_addr_i),
        .acc_cs_n_i     (acc_cs_n_i),
        .acc_type_i     (acc_type_i),
        .acc_addr_i     (acc_addr_i),
        .acc_be_i       (acc_be_i),
        .acc_wdata_i    (acc_wdata_i),
        .acc_wait_n_o   (acc_wait_n_o),
        .acc_rdata_o    (acc_rdata_o),
        .tcdm_req_o     (tcdm_req_o),
        .tcdm_gnt_i     (tcdm_gnt_i),
        .tcdm_add_o     (tcdm_add_o),
        .tcdm_type_o    (tcdm_type_o),
        .tcdm_be_o      (tcdm_be_o),
        .tcdm_data_o    (tcdm_data_o),
        .tcdm_r_data_i  (tcdm_r_data_i),
        .tcdm_r_valid_i (tcdm_r_valid_i),
        .busy_o         (busy_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp)
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        else
            n_pass++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Read on port p; request already asserted while the DUT sits in IDLE.
    task automatic read_xact(input int p, input int gnt_dly, input int rv_dly, input logic [31:0] rdata);
        logic [31:0] exp_add;
        exp_add = base_m[p] + (addr_m[p] << 2);
        step();
        check($sformatf("rd%0d_req", p),  32'(tcdm_req_o), 32'd1);
        check($sformatf("rd%0d_add", p),  tcdm_add_o, exp_add);
        check($sformatf("rd%0d_type", p), 32'(tcdm_type_o), 32'd1);
        check($sformatf("rd%0d_wait", p), 32'(acc_wait_n_o[p]), 32'd0);
        for (int k = 0; k < gnt_dly; k++) begin
            step();
            check($sformatf("rd%0d_req_hold", p), 32'(tcdm_req_o), 32'd1);
            check($sformatf("rd%0d_add_hold", p), tcdm_add_o, exp_add);
            check($sformatf("rd%0d_wait_hold", p), 32'(acc_wait_n_o[p]), 32'd0);
        end
        tcdm_gnt_i = 1'b1;
        step();
        tcdm_gnt_i = 1'b0;
        check($sformatf("rd%0d_req_drop", p), 32'(tcdm_req_o), 32'd0);
        for (int k = 1; k < rv_dly; k++) begin
            check($sformatf("rd%0d_wait_resp", p), 32'(acc_wait_n_o[p]), 32'd0);
            step();
        end
        tcdm_r_valid_i = 1'b1;
        tcdm_r_data_i  = rdata;
        step();
        tcdm_r_valid_i = 1'b0;
        tcdm_r_data_i  = 32'h0;
        check($sformatf("rd%0d_ack", p),   32'(acc_wait_n_o[p]), 32'd1);
        check($sformatf("rd%0d_rdata", p), acc_rdata_o, rdata);
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; en_i = 1'b1; acc_cs_n_i = 4'hF; acc_type_i = 4'h0;
        tcdm_gnt_i = 1'b0; tcdm_r_valid_i = 1'b0; tcdm_r_data_i = 32'h0;
        base_m  = '{32'h2000_0000, 32'h2000_0100, 32'h1000_0000, 32'h2000_0300};
        addr_m  = '{32'd0, 32'd1, 32'd5, 32'd3};
        wdata_m = '{32'h0, 32'h0, 32'hDEAD_BEEF, 32'h0};
        be_m    = '{4'hF, 4'hF, 4'hF, 4'hF};

        // Reset state
        step(); step();
        check("rst_req",   32'(tcdm_req_o), 32'd0);
        check("rst_add",   tcdm_add_o, 32'd0);
        check("rst_type",  32'(tcdm_type_o), 32'd0);
        check("rst_be",    32'(tcdm_be_o), 32'd0);
        check("rst_data",  tcdm_data_o, 32'd0);
        check("rst_rdata", acc_rdata_o, 32'd0);
        check("rst_busy",  32'(busy_o), 32'd0);
        check("rst_wait",  32'(acc_wait_n_o), 32'hF);
        rst_n = 1'b1;
        step();

        // Port 2 write, immediate grant
        acc_type_i = 4'b0100; acc_cs_n_i = 4'b1011;
        #1 check("wr2_stall", 32'(acc_wait_n_o), 32'b1011);
        step();
        check("wr2_busy", 32'(busy_o), 32'd1);
        check("wr2_req",  32'(tcdm_req_o), 32'd1);
        check("wr2_add",  tcdm_add_o, 32'h1000_0014);
        check("wr2_type", 32'(tcdm_type_o), 32'd0);
        check("wr2_data", tcdm_data_o, 32'hDEAD_BEEF);
        check("wr2_be",   32'(tcdm_be_o), 32'hF);
        tcdm_gnt_i = 1'b1;
        step();
        tcdm_gnt_i = 1'b0;
        check("wr2_req_drop", 32'(tcdm_req_o), 32'd0);
        check("wr2_ack",      32'(acc_wait_n_o), 32'hF);
        acc_cs_n_i = 4'hF;
        step();
        check("wr2_idle", 32'(busy_o), 32'd0);

        // ptr is now 3: ports 0 and 3 compete, 3 must win
        acc_type_i = 4'h0; acc_cs_n_i = 4'b0110;
        read_xact(3, 0, 1, 32'h0000_00C3);

        // All ports reading continuously from ptr=0
        acc_cs_n_i = 4'h0;
        read_xact(0, 0, 1, 32'h0000_00A0);
        read_xact(1, 0, 1, 32'h0000_00A1);
        read_xact(2, 0, 1, 32'h0000_00A2);
        read_xact(3, 0, 1, 32'h0000_00A3);
        read_xact(0, 0, 1, 32'h0000_00A0);

        // Delayed grant (3 cycles) and delayed response (2 cycles) on port 1
        acc_cs_n_i = 4'b1101;
        read_xact(1, 3, 2, 32'h1234_5678);
        acc_cs_n_i = 4'hF;

        // Enable low blocks new grants
        en_i = 1'b0; acc_type_i = 4'b0001; acc_cs_n_i = 4'b1110;
        base_m[0] = 32'hFFFF_FFF0; addr_m[0] = 32'd8;
        step(); step();
        check("en_block_busy", 32'(busy_o), 32'd0);
        check("en_block_wait", 32'(acc_wait_n_o), 32'b1110);

        // Address wrap on port 0 write; rdata must hold the last response
        en_i = 1'b1;
        step();
        check("wrap_add",  tcdm_add_o, 32'h0000_0010);
        check("wrap_type", 32'(tcdm_type_o), 32'd0);
        tcdm_gnt_i = 1'b1;
        step();
        tcdm_gnt_i = 1'b0;
        check("wrap_ack",        32'(acc_wait_n_o), 32'hF);
        check("rdata_hold",      acc_rdata_o, 32'h1234_5678);
        acc_cs_n_i = 4'hF;
        step();

        // Reset during RESP, then stale r_valid
        acc_type_i = 4'h0; acc_cs_n_i = 4'b0111;
        step();
        check("rr_add", tcdm_add_o, 32'h2000_030C);
        tcdm_gnt_i = 1'b1;
        step();
        tcdm_gnt_i = 1'b0;
        check("rr_in_resp", 32'(busy_o), 32'd1);
        rst_n = 1'b0; acc_cs_n_i = 4'hF;
        #1;
        check("rr_busy", 32'(busy_o), 32'd0);
        check("rr_req",  32'(tcdm_req_o), 32'd0);
        step();
        rst_n = 1'b1;
        tcdm_r_valid_i = 1'b1; tcdm_r_data_i = 32'h0000_0BAD;
        step();
        tcdm_r_valid_i = 1'b0;
        check("stale_busy",  32'(busy_o), 32'd0);
        check("stale_rdata", acc_rdata_o, 32'd0);
        check("stale_wait",  32'(acc_wait_n_o), 32'hF);
        step();
        check("stale_idle", 32'(busy_o), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
